cic_decimator: RTL
==================

// Module: cic_decimator
// PURPOSE
//  Parametrised cascaded-integrator-comb decimator, successor to the fixed 3-stage accumulator chain.
//  STAGES integrators run at input rate. A phase counter keeps every RATE-th accepted sample.
//  STAGES comb stages at decimated rate give a full-precision output.
//  Sits between sample source and downstream DSP; gain = RATE**STAGES, no truncation.
// PARAMETERS
//  IN_W      4  input sample width
//  STAGES    3  integrator count = comb count (>=1)
//  RATE      4  decimation factor (>=1); phase counter width clog2(RATE), min 1
//  SIGNED_IN 0  0: in_data unsigned (zero-extend); 1: two's complement (sign-extend)
//  ACC_W derived (localparam) = IN_W + STAGES*clog2(RATE); all internal regs ACC_W wide
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  clear     in   1      synchronous clear of all state
//  in_valid  in   1      in_data accepted on this edge when high
//  in_data   in   IN_W   input sample
//  out_valid out  1      one-cycle pulse: out_data holds a new decimated sample
//  out_data  out  ACC_W  decimated output, held until next out_valid
// BEHAVIOUR
//  Reset (reset=0, async): integrators, comb delays, comb pipe regs, phase, out_data=0, out_valid=0, immediately.
//  clear=1 at an edge: same zeroing as reset; overrides in_valid; any in-flight output is discarded.
//  Integrators, registered cascade, only on in_valid=1:
//   i[0] <= i[0] + ext(in_data); i[k] <= i[k] + i[k-1] (pre-edge value of i[k-1]).
//   in_valid=0: integrators and phase hold.
//  Arithmetic: modulo 2**ACC_W, wrap is intended; no saturation; comb output exact by construction.
//  Phase: counts accepted samples 0..RATE-1, wraps to 0. RATE=1: every accepted sample is kept.
//  Strobe edge E0: in_valid=1 and phase==RATE-1.
//   Comb stage 0 registers c[0] <= inext - d[0] and d[0] <= inext.
//   inext = post-edge value of i[STAGES-1] (this sample's contribution included).
//  Comb stage k (k>=1) registers at edge E0+k: c[k] <= c[k-1] - d[k]; d[k] <= c[k-1].
//   Delay regs update only when their stage's valid bit is set.
//  Valid bit shifts with data through the comb stages every cycle, independent of in_valid.
//  out_data = c[STAGES-1]. out_valid is high for exactly the one cycle after edge E0+STAGES-1.
//   Latency: STAGES-1 edges after the strobe edge.
//  Back-to-back strobes (RATE=1, in_valid held high): one output per cycle, no stall, no loss.
//  Strobe on the same edge as clear: dropped.
//  Reset mid-pipeline: pending outputs lost; the first output after release needs RATE new samples.
// STRUCTURE
//  Shared package dsp_pkg: clog2 function and the CIC width formula (ACC_W); no typedefs needed.
//  Sub-module cic_integrator_stage (ACC_W wide, en, clear, din, q); instantiated STAGES times via generate.
//  Comb stages, phase counter and valid shift register stay inline in this module.
// TESTING
//  1. Defaults, in_data=1 held with in_valid=1 from clear -> out_data sequence 4,44,64,64,...
//     out_valid once per 4 accepted samples.
//  2. Defaults, in_data=15 constant -> steady-state out_data=960 (15*64); intermediate wrap is harmless.
//  3. SIGNED_IN=1, in_data=4'b1000 (-8) constant -> steady out_data=10'h200 (-512).
//  4. in_valid toggling 1/0 with in_data=1 -> same value sequence as test 1; out_valid spacing 8 cycles.
//  5. RATE=1, STAGES=2, in_data ramp 0..15 -> out_valid every cycle.
//     out_data = in_data delayed by pipeline; latency exactly STAGES-1 edges after strobe.
//  6. reset low for 1 cycle mid-pipeline, then clear during a strobe -> outputs 0 and out_valid 0 immediately.
//     No stale pulse; test 1 sequence restarts at 4.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP helpers: ceiling log2 and the CIC accumulator width formula.
package dsp_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Full-precision CIC register width: input width plus log2 of the gain RATE**STAGES.
   function automatic int unsigned cic_acc_w(input int unsigned in_w,
                                             input int unsigned stages,
                                             input int unsigned rate);
      return in_w + stages * clog2(rate);
   endfunction

   function automatic int unsigned phase_w(input int unsigned rate);
      return (clog2(rate) == 0) ? 1 : clog2(rate);
   endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: wrapping accumulator that adds din on each enabled edge.
module cic_integrator_stage #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (en) begin
         q <= q + din;
      end
   end

endmodule

// File: rtl/cic_decimator.sv
// Parametrised CIC decimator: STAGES integrators at input rate, keep every RATE-th
// accepted sample, STAGES comb stages at decimated rate, full-precision output.
module cic_decimator
   import dsp_pkg::*;
#(
   parameter int  IN_W      = 4,
   parameter int  STAGES    = 3,
   parameter int  RATE      = 4,
   parameter int  SIGNED_IN = 0,
   localparam int ACC_W     = cic_acc_w(IN_W, STAGES, RATE)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data
);

   localparam int PH_W = phase_w(RATE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE - 1);

   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_int_d [STAGES];
   logic [ACC_W-1:0] w_int_q [STAGES];
   logic [ACC_W-1:0] w_inext;
   logic             w_strobe;

   logic [PH_W-1:0]   r_phase;
   logic [ACC_W-1:0]  r_comb [STAGES];
   logic [ACC_W-1:0]  r_dly  [STAGES];
   logic [STAGES-1:0] r_vld;

   if (SIGNED_IN != 0) begin : g_sext
      assign w_ext = ACC_W'(signed'(in_data));
   end else begin : g_zext
      assign w_ext = ACC_W'(in_data);
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_int
      if (g == 0) begin : g_first
         assign w_int_d[g] = w_ext;
      end else begin : g_next
         assign w_int_d[g] = w_int_q[g-1];
      end

      cic_integrator_stage #(
         .W (ACC_W)
      ) u_stage (
         .clock (clock),
         .reset (reset),
         .en    (in_valid),
         .clear (clear),
         .din   (w_int_d[g]),
         .q     (w_int_q[g])
      );
   end

   // Post-edge value of the last integrator, so the strobing sample is included.
   assign w_inext  = w_int_q[STAGES-1] + w_int_d[STAGES-1];
   assign w_strobe = in_valid && !clear && (r_phase == PH_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_phase <= '0;
      end else if (clear) begin
         r_phase <= '0;
      end else if (in_valid) begin
         r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_comb[k] <= '0;
            r_dly[k]  <= '0;
         end
         r_vld <= '0;
      end else if (clear) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_comb[k] <= '0;
            r_dly[k]  <= '0;
         end
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_strobe;
         if (w_strobe) begin
            r_comb[0] <= w_inext - r_dly[0];
            r_dly[0]  <= w_inext;
         end
         // Each comb stage fires one edge after its predecessor, gated by the travelling valid bit.
         for (int unsigned k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
               r_comb[k] <= r_comb[k-1] - r_dly[k];
               r_dly[k]  <= r_comb[k-1];
            end
         end
      end
   end

   assign out_data  = r_comb[STAGES-1];
   assign out_valid = r_vld[STAGES-1];

endmodule
